// File: rtl/rate_updown_counter.sv
// Rate-paced up/down counter: a runtime-selectable clock-enable divider steps a
// WIDTH-bit counter with wrap/saturate bounds, pause and parallel load.
module rate_updown_counter #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 26,
    parameter int RATE0 = 1,
    parameter int RATE1 = 5,
    parameter int RATE2 = 10,
    parameter int RATE3 = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       speed,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    // tick acts as the step qualifier: a step is taken only on an edge where
    // tick (the registered divider pulse) and en are both high.
    logic [DIV_W-1:0] r_div;
    logic [WIDTH-1:0] r_count;
    logic             r_tick;
    logic             r_tc;

    logic [DIV_W-1:0] w_reload;
    logic             w_rate_ok;
    logic             w_step;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_bound;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_reload  = DIV_W'(RATE0 - 1);
        w_rate_ok = (RATE0 > 0);
        case (speed)
            2'b00: begin
                w_reload  = DIV_W'(RATE0 - 1);
                w_rate_ok = (RATE0 > 0);
            end
            2'b01: begin
                w_reload  = DIV_W'(RATE1 - 1);
                w_rate_ok = (RATE1 > 0);
            end
            2'b10: begin
                w_reload  = DIV_W'(RATE2 - 1);
                w_rate_ok = (RATE2 > 0);
            end
            default: begin
                w_reload  = DIV_W'(RATE3 - 1);
                w_rate_ok = (RATE3 > 0);
            end
        endcase
    end

    a_rate_nonzero: assert property (@(posedge clk) w_rate_ok);

    assign w_step   = r_tick & en;
    assign w_at_max = &r_count;
    assign w_at_min = ~|r_count;
    assign w_bound  = up ? w_at_max : w_at_min;

    // Crossing a bound either wraps naturally through modular arithmetic or
    // is blocked in saturate mode; both cases raise tc.
    always_comb begin
        w_next = r_count;
        if (!(sat && w_bound)) begin
            w_next = up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= w_reload;
            r_tick <= 1'b0;
        end else if (en) begin
            if (r_div == '0) begin
                r_div  <= w_reload;
                r_tick <= 1'b1;
            end else begin
                r_div  <= r_div - DIV_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= load_value;
            r_tc    <= 1'b0;
        end else if (w_step) begin
            r_count <= w_next;
            r_tc    <= w_bound;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count = r_count;
    assign tick  = r_tick;
    assign tc    = r_tc;

endmodule
